// File: rtl/expr_pipe_pkg.sv
// Shared types, constants and helpers for the expr_pipe_hs arithmetic pipeline.
package expr_pipe_pkg;

  // Per-transaction operation select for the C/D term.
  typedef enum logic {
    OP_SUB = 1'b0,
    OP_ADD = 1'b1
  } op_e;

  // Number of register slices between operand acceptance and result.
  localparam int STAGES = 3;

  // Width of the occupancy count, wide enough to hold 0..STAGES.
  localparam int OCCW = $clog2(STAGES + 1);

  // Full-precision signed result width for N-bit unsigned operands.
  function automatic int res_width(input int n);
    return 2 * n + 3;
  endfunction

endpackage

// File: rtl/expr_pipe_hs_if.sv
// Operand/result handshake bundle for expr_pipe_hs.
// master = operand producer and result consumer, slave = the pipeline.
interface expr_pipe_hs_if
  import expr_pipe_pkg::*;
#(
  parameter int N    = 10,
  parameter int TAGW = 4
);

  localparam int OW = res_width(N);

  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0]           A;
  logic [N-1:0]           B;
  logic [N-1:0]           C;
  logic [N-1:0]           D;
  logic                   op;
  logic [TAGW-1:0]        in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [OW-1:0]   F;
  logic [TAGW-1:0]        out_tag;
  logic [OCCW-1:0]        occupancy;

  modport master (
    output in_valid, A, B, C, D, op, in_tag, out_ready,
    input  in_ready, out_valid, F, out_tag, occupancy
  );

  modport slave (
    input  in_valid, A, B, C, D, op, in_tag, out_ready,
    output in_ready, out_valid, F, out_tag, occupancy
  );

endinterface

// File: rtl/pipe_slice.sv
// One elastic valid/ready register slice. Accepts new data whenever it is
// empty or its current content is being taken downstream in the same cycle.
module pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         ready_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         v;
  logic [W-1:0] data;

  assign ready_out = !v || out_ready;
  assign out_valid = v;
  assign out_data  = data;

  // Slice state: valid follows upstream on advance, data loads only on a real transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      v    <= 1'b0;
      // NOTE: the payload is cleared on reset too, so F/out_tag read 0 right after reset.
      data <= '0;
    end else if (ready_out) begin
      v <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/expr_pipe_hs.sv
// Flow-controlled 3-stage pipeline computing F = ((A+B) + (C op D)) * D at
// full precision. Three pipe_slice instances form the elastic chain; all
// arithmetic lives here between the slices.
module expr_pipe_hs
  import expr_pipe_pkg::*;
#(
  parameter int N    = 10,
  parameter int TAGW = 4
) (
  input logic               clk,
  input logic               rst,
  expr_pipe_hs_if.slave     bus
);

  localparam int OW = res_width(N);
  localparam int W1 = (N + 1) + (N + 2) + N + TAGW;
  localparam int W2 = (N + 3) + N + TAGW;
  localparam int W3 = OW + TAGW;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: x1 = A+B, x2 = C +/- D
  // ---------------------------------------------------------------------------
  logic [N:0]          x1;
  logic signed [N+1:0] c_s;
  logic signed [N+1:0] d_s;
  logic signed [N+1:0] x2;

  assign x1  = {1'b0, bus.A} + {1'b0, bus.B};
  assign c_s = signed'({2'b00, bus.C});
  assign d_s = signed'({2'b00, bus.D});
  assign x2  = (bus.op == OP_ADD) ? (c_s + d_s) : (c_s - d_s);

  logic [W1-1:0] s1_in;
  logic [W1-1:0] s1_q;
  logic          v1;
  logic          ready1;

  assign s1_in = {x1, x2, bus.D, bus.in_tag};

  logic [N:0]          s1_x1;
  logic signed [N+1:0] s1_x2;
  logic [N-1:0]        s1_d;
  logic [TAGW-1:0]     s1_tag;

  assign {s1_x1, s1_x2, s1_d, s1_tag} = s1_q;

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: x3 = x1 + x2
  // ---------------------------------------------------------------------------
  logic signed [N+2:0] x3;

  assign x3 = signed'({2'b00, s1_x1}) + signed'({s1_x2[N+1], s1_x2});

  logic [W2-1:0] s2_in;
  logic [W2-1:0] s2_q;
  logic          v2;
  logic          ready2;

  assign s2_in = {x3, s1_d, s1_tag};

  logic signed [N+2:0] s2_x3;
  logic [N-1:0]        s2_d;
  logic [TAGW-1:0]     s2_tag;

  assign {s2_x3, s2_d, s2_tag} = s2_q;

  // ---------------------------------------------------------------------------
  // Stage 3 combinational: F = x3 * D, both sign-extended to the result width
  // so the product is exact (the true range fits in OW bits).
  // ---------------------------------------------------------------------------
  logic signed [OW-1:0] x3_w;
  logic signed [OW-1:0] d_w;
  logic signed [OW-1:0] prod;

  assign x3_w = OW'(s2_x3);
  assign d_w  = OW'(signed'({1'b0, s2_d}));
  assign prod = x3_w * d_w;

  logic [W3-1:0] s3_in;
  logic [W3-1:0] s3_q;
  logic          v3;
  logic          ready3;

  assign s3_in = {prod, s2_tag};

  // ---------------------------------------------------------------------------
  // Elastic chain
  // ---------------------------------------------------------------------------
  pipe_slice #(.W(W1)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_data   (s1_in),
    .ready_out (ready1),
    .out_valid (v1),
    .out_ready (ready2),
    .out_data  (s1_q)
  );

  pipe_slice #(.W(W2)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .in_data   (s2_in),
    .ready_out (ready2),
    .out_valid (v2),
    .out_ready (ready3),
    .out_data  (s2_q)
  );

  pipe_slice #(.W(W3)) u_s3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v2),
    .in_data   (s3_in),
    .ready_out (ready3),
    .out_valid (v3),
    .out_ready (bus.out_ready),
    .out_data  (s3_q)
  );

  // Inputs are refused while reset is held, even if the chain is empty.
  assign bus.in_ready  = ready1 && !rst;
  assign bus.out_valid = v3;
  assign {bus.F, bus.out_tag} = s3_q;

  // ---------------------------------------------------------------------------
  // Occupancy: registered count of valid stages
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            pop;
  logic [OCCW-1:0] occ;
  logic [OCCW-1:0] occ_next;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = v3 && bus.out_ready;

  // Next occupancy: up on push-only, down on pop-only, hold otherwise.
  always_comb begin
    // NOTE: default assigned first so no path leaves occ_next unassigned (no latch).
    occ_next = occ;
    if (accept && !pop) begin
      occ_next = occ + OCCW'(1);
    end else if (!accept && pop) begin
      occ_next = occ - OCCW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else begin
      occ <= occ_next;
    end
  end

  assign bus.occupancy = occ;

endmodule

// File: tb/tb_expr_pipe_hs.sv
// Self-checking bench for expr_pipe_hs: directed scenarios plus a short
// random phase, with a scoreboard queue filled on every accepted input and
// drained on every result handshake.
module tb_expr_pipe_hs;
  import expr_pipe_pkg::*;

  localparam int N    = 10;
  localparam int TAGW = 4;
  localparam int OW   = res_width(N);

  typedef struct {
    logic [TAGW-1:0] tag;
    longint          f;
  } exp_t;

  logic clk;
  logic rst;

  expr_pipe_hs_if #(.N(N), .TAGW(TAGW)) bus ();

  expr_pipe_hs #(.N(N), .TAGW(TAGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   occ_model = 0;
  exp_t sb[$];

  // Reference arithmetic in plain integers.
  function automatic longint model(input int a, input int b, input int c, input int d,
                                   input logic o);
    longint t;
    t = longint'(a) + longint'(b);
    t = t + (o ? (longint'(c) + longint'(d)) : (longint'(c) - longint'(d)));
    return t * longint'(d);
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input int c, input int d,
                       input logic o, input int t);
    bus.in_valid = 1'b1;
    bus.A        = a[N-1:0];
    bus.B        = b[N-1:0];
    bus.C        = c[N-1:0];
    bus.D        = d[N-1:0];
    bus.op       = o;
    bus.in_tag   = t[TAGW-1:0];
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // One clock edge: evaluate handshakes at the falling edge, update the
  // scoreboard and occupancy model, then sample state 1 time unit after the edge.
  task automatic cycle();
    logic                 acc;
    logic                 pop;
    logic                 hold;
    logic signed [OW-1:0] f_prev;
    logic [TAGW-1:0]      t_prev;
    exp_t                 e;
    @(negedge clk);
    check("in_ready", bus.in_ready, !rst && !(occ_model == 3 && !bus.out_ready));
    acc    = !rst && bus.in_valid && bus.in_ready;
    pop    = !rst && bus.out_valid && bus.out_ready;
    hold   = !rst && bus.out_valid && !bus.out_ready;
    f_prev = bus.F;
    t_prev = bus.out_tag;
    if (pop) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", bus.out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("sb_F", bus.F, e.f);
        check("sb_out_tag", bus.out_tag, e.tag);
      end
    end
    if (acc) begin
      e.tag = bus.in_tag;
      e.f   = model(bus.A, bus.B, bus.C, bus.D, bus.op);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      occ_model = 0;
      sb.delete();
    end else begin
      occ_model = occ_model + int'(acc) - int'(pop);
    end
    check("occupancy", bus.occupancy, occ_model);
    if (hold) begin
      check("stall_F", bus.F, f_prev);
      check("stall_out_tag", bus.out_tag, t_prev);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && sb.size() != 0; i++) cycle();
    check(tag, sb.size(), 0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
  endtask

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.C         = '0;
    bus.D         = '0;
    bus.op        = OP_SUB;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset: in_ready held low, then everything reads zero.
    repeat (2) cycle();
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_F", bus.F, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_occupancy", bus.occupancy, 0);

    // 1. Single transaction, no stall.
    bus.out_ready = 1'b1;
    drive(10, 15, 18, 15, OP_SUB, 1);
    cycle();
    idle();
    cycle();
    check("t1_not_early", bus.out_valid, 1'b0);
    cycle();
    check("t1_out_valid", bus.out_valid, 1'b1);
    check("t1_F", bus.F, 420);
    cycle();

    // 2. Back-to-back results on consecutive cycles.
    drive(10, 15, 18, 15, OP_SUB, 2);
    cycle();
    drive(13, 32, 30, 21, OP_SUB, 3);
    cycle();
    idle();
    cycle();
    check("t2_F_first", bus.F, 420);
    cycle();
    check("t2_out_valid_second", bus.out_valid, 1'b1);
    check("t2_F_second", bus.F, 1134);
    check("t2_tag_second", bus.out_tag, 3);
    cycle();

    // 3. Most negative and most positive results.
    drive(0, 0, 0, 1023, OP_SUB, 4);
    cycle();
    drive(1023, 1023, 1023, 1023, OP_ADD, 5);
    cycle();
    idle();
    cycle();
    check("t3_F_min", bus.F, -1046529);
    cycle();
    check("t3_F_max", bus.F, 4186116);
    drain("t3_drain");

    // 4. Backpressure: fourth input is refused, output holds.
    bus.out_ready = 1'b0;
    drive(1, 2, 3, 4, OP_ADD, 1);
    cycle();
    drive(5, 6, 7, 8, OP_SUB, 2);
    cycle();
    drive(100, 200, 300, 400, OP_ADD, 3);
    cycle();
    drive(9, 9, 9, 9, OP_SUB, 4);
    cycle();
    check("t4_in_ready_full", bus.in_ready, 1'b0);
    check("t4_occupancy_full", bus.occupancy, 3);
    check("t4_out_tag", bus.out_tag, 1);
    check("t4_F", bus.F, 40);
    repeat (2) cycle();
    check("t4_out_tag_held", bus.out_tag, 1);
    check("t4_F_held", bus.F, 40);
    bus.out_ready = 1'b1;
    #2;
    check("t4_in_ready_poppush", bus.in_ready, 1'b1);
    cycle();
    check("t4_occupancy_poppush", bus.occupancy, 3);
    idle();
    drain("t4_drain");

    // 5. Full pipeline with continuous pop and push.
    bus.out_ready = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      drive(k, k + 2, k * 11, k * 5, 1'(k), k);
      cycle();
    end
    idle();
    check("t5_occupancy_full", bus.occupancy, 3);
    bus.out_ready = 1'b1;
    for (int k = 8; k <= 10; k++) begin
      drive(k, k + 1, k * 3, k * 7, 1'(k), k);
      #2;
      check("t5_in_ready", bus.in_ready, 1'b1);
      cycle();
      check("t5_occupancy", bus.occupancy, 3);
    end
    idle();
    drain("t5_drain");

    // 6. Reset with two transactions in flight.
    bus.out_ready = 1'b0;
    drive(50, 60, 70, 80, OP_ADD, 11);
    cycle();
    drive(1, 1, 1, 1, OP_SUB, 12);
    cycle();
    idle();
    check("t6_occupancy_pre", bus.occupancy, 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_out_valid", bus.out_valid, 1'b0);
    check("t6_occupancy", bus.occupancy, 0);
    check("t6_F", bus.F, 0);
    check("t6_out_tag", bus.out_tag, 0);
    bus.out_ready = 1'b1;
    drive(7, 9, 100, 3, OP_ADD, 13);
    cycle();
    idle();
    repeat (2) cycle();
    check("t6_post_out_valid", bus.out_valid, 1'b1);
    check("t6_post_F", bus.F, 357);
    check("t6_post_tag", bus.out_tag, 13);
    drain("t6_drain");

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      end else begin
        idle();
      end
      cycle();
    end
    idle();
    bus.out_ready = 1'b1;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
